tdc_meas_ctrl: RTL

//  Measurement sequencer for the TDC core (pulse gen + delay line + capture/sync + popcount).
//  On start it enables the core and issues a burst of pg_tog launches. After each launch it

---
 rtl/tdc_meas_ctrl_pkg.sv | 41 ++++
 rtl/tdc_meas_ctrl_if.sv | 27 ++
 rtl/tdc_meas_ctrl_stat_accum.sv | 47 ++++
 rtl/tdc_meas_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/tdc_meas_ctrl_pkg.sv
// Shared constants, widths, FSM state type and result record for the TDC measurement sequencer.
package tdc_meas_ctrl_pkg;

  localparam int unsigned N        = 64;
  localparam int unsigned LAT      = 3;
  localparam int unsigned ARM_CYC  = 2;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SETTLE_W = 4;

  function automatic int unsigned hw_width(input int unsigned taps);
    return $clog2(taps) + 1;
  endfunction

  function automatic int unsigned acc_width(input int unsigned taps, input int unsigned cnt_w);
    return hw_width(taps) + cnt_w;
  endfunction

  localparam int unsigned HW_W   = hw_width(N);
  localparam int unsigned ACC_W  = acc_width(N, CNT_W);
  localparam int unsigned RCNT_W = CNT_W + 1;
  // One timer serves ARM, WAIT and SETTLE; SETTLE needs the widest range.
  localparam int unsigned TMR_W  = SETTLE_W;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    WAIT,
    SAMPLE,
    SETTLE,
    DONE
  } ctrl_state_t;

  typedef struct packed {
    logic [ACC_W-1:0]  sum;
    logic [HW_W-1:0]   hw_min;
    logic [HW_W-1:0]   hw_max;
    logic [RCNT_W-1:0] cnt;
  } res_rec_t;

endpackage

// File: rtl/tdc_meas_ctrl_if.sv
// Request / result-record bus between a host and the TDC measurement sequencer.
interface tdc_meas_ctrl_if;
  import tdc_meas_ctrl_pkg::*;

  logic                start;
  logic                abort;
  logic [CNT_W-1:0]    n_samples;
  logic [SETTLE_W-1:0] settle;
  logic                busy;
  logic                res_valid;
  logic                res_ready;
  logic [ACC_W-1:0]    res_sum;
  logic [HW_W-1:0]     res_min;
  logic [HW_W-1:0]     res_max;
  logic [RCNT_W-1:0]   res_cnt;

  modport master (
    output start, abort, n_samples, settle, res_ready,
    input  busy, res_valid, res_sum, res_min, res_max, res_cnt
  );

  modport slave (
    input  start, abort, n_samples, settle, res_ready,
    output busy, res_valid, res_sum, res_min, res_max, res_cnt
  );

endinterface

// File: rtl/tdc_meas_ctrl_stat_accum.sv
// Burst statistics: clamped hamming-weight sum, min, max and sample count.
module tdc_meas_ctrl_stat_accum
  import tdc_meas_ctrl_pkg::*;
(
  input  logic            clk_capture,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic [HW_W-1:0] hw_i,
  output res_rec_t        res_o
);

  res_rec_t        res_q;
  res_rec_t        res_d;
  logic [HW_W-1:0] hw_c;

  // A fresh record loads min/max from the first sample regardless of their reset values.
  always_comb begin
    hw_c  = (hw_i > HW_W'(N)) ? HW_W'(N) : hw_i;
    res_d = res_q;
    if (clear_i) begin
      res_d.sum    = '0;
      res_d.hw_min = '1;
      res_d.hw_max = '0;
      res_d.cnt    = '0;
    end else if (en_i) begin
      res_d.sum = res_q.sum + ACC_W'(hw_c);
      res_d.cnt = res_q.cnt + RCNT_W'(1);
      if ((res_q.cnt == '0) || (hw_c < res_q.hw_min)) res_d.hw_min = hw_c;
      if ((res_q.cnt == '0) || (hw_c > res_q.hw_max)) res_d.hw_max = hw_c;
    end
  end

  always_ff @(posedge clk_capture) begin
    if (rst) begin
      res_q.sum    <= '0;
      res_q.hw_min <= '1;
      res_q.hw_max <= '0;
      res_q.cnt    <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arms the core, issues a burst of launches, samples each result
// a fixed pipeline latency later and presents one sum/min/max/count record.
module tdc_meas_ctrl
  import tdc_meas_ctrl_pkg::*;
(
  input  logic            clk_capture,
  input  logic            rst,
  tdc_meas_ctrl_if.slave  ctrl_if,
  output logic            tdc_en_o,
  output logic            tdc_pg_tog_o,
  input  logic [HW_W-1:0] tdc_hw_i
);

  ctrl_state_t         state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [RCNT_W-1:0]   remaining_q, remaining_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                busy_q, busy_d;
  logic                tdc_en_q, tdc_en_d;
  logic                pg_tog_q, pg_tog_d;
  logic                res_valid_q, res_valid_d;
  logic                clear_c;
  logic                sample_c;
  res_rec_t            res;

  // Next state; registered outputs are decoded from the next state so they align with it.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    settle_d    = settle_q;
    clear_c     = 1'b0;
    sample_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl_if.start && !ctrl_if.abort) begin
          state_d     = ARM;
          timer_d     = TMR_W'(ARM_CYC - 1);
          remaining_d = (ctrl_if.n_samples == '0) ? RCNT_W'(2 ** CNT_W)
                                                  : {1'b0, ctrl_if.n_samples};
          settle_d    = ctrl_if.settle;
          clear_c     = 1'b1;
        end
      end
      ARM: begin
        if (timer_q == '0) state_d = LAUNCH;
        else               timer_d = timer_q - TMR_W'(1);
      end
      LAUNCH: begin
        state_d = WAIT;
        timer_d = TMR_W'(LAT - 2);
      end
      WAIT: begin
        if (timer_q == '0) state_d = SAMPLE;
        else               timer_d = timer_q - TMR_W'(1);
      end
      SAMPLE: begin
        sample_c    = 1'b1;
        remaining_d = remaining_q - RCNT_W'(1);
        if (settle_q != '0) begin
          state_d = SETTLE;
          timer_d = settle_q - TMR_W'(1);
        end else if (remaining_q == RCNT_W'(1)) begin
          state_d = DONE;
        end else begin
          state_d = LAUNCH;
        end
      end
      SETTLE: begin
        if (timer_q == '0) state_d = (remaining_q == '0) ? DONE : LAUNCH;
        else               timer_d = timer_q - TMR_W'(1);
      end
      DONE: begin
        if (ctrl_if.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && ctrl_if.abort) state_d = IDLE;

    busy_d      = (state_d != IDLE);
    tdc_en_d    = (state_d inside {ARM, LAUNCH, WAIT, SAMPLE, SETTLE});
    pg_tog_d    = (state_d == LAUNCH);
    res_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_capture) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      settle_q    <= '0;
      busy_q      <= 1'b0;
      tdc_en_q    <= 1'b0;
      pg_tog_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      settle_q    <= settle_d;
      busy_q      <= busy_d;
      tdc_en_q    <= tdc_en_d;
      pg_tog_q    <= pg_tog_d;
      res_valid_q <= res_valid_d;
    end
  end

  tdc_meas_ctrl_stat_accum u_stat (
    .clk_capture (clk_capture),
    .rst         (rst),
    .clear_i     (clear_c),
    .en_i        (sample_c),
    .hw_i        (tdc_hw_i),
    .res_o       (res)
  );

  assign tdc_en_o          = tdc_en_q;
  assign tdc_pg_tog_o      = pg_tog_q;
  assign ctrl_if.busy      = busy_q;
  assign ctrl_if.res_valid = res_valid_q;
  assign ctrl_if.res_sum   = res.sum;
  assign ctrl_if.res_min   = res.hw_min;
  assign ctrl_if.res_max   = res.hw_max;
  assign ctrl_if.res_cnt   = res.cnt;

endmodule
